// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 receiver.
package ps2_pkg;

   localparam logic [7:0]  PS2_EXT        = 8'hE0;
   localparam logic [7:0]  PS2_BRK        = 8'hF0;
   localparam int unsigned PS2_FRAME_BITS = 11;

   // start + parity + stop surround the data bits
   localparam int unsigned PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } ps2_rx_state_e;

   typedef struct packed {
      logic       pressed;
      logic       extended;
      logic [7:0] code;
   } ps2_evt_t;

   // Odd parity: data ones plus parity bit must be odd.
   function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous byte FIFO, 2^FIFO_BITS entries; full/empty via an extra pointer MSB.
module ps2_byte_fifo #(
   parameter int unsigned FIFO_BITS = 3
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int unsigned Depth = 2 ** FIFO_BITS;

   logic [7:0]         mem [Depth];
   logic [FIFO_BITS:0] wr_ptr_q;
   logic [FIFO_BITS:0] rd_ptr_q;
   logic               push_ok;
   logic               pop_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                    (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr_q[FIFO_BITS-1:0]];

   // Pointer update; pointers wrap naturally through the extra MSB.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage write; contents need no reset because the pointers gate reads.
   always_ff @(posedge clk_sys) begin
      if (push_ok) mem[wr_ptr_q[FIFO_BITS-1:0]] <= din;
   end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 receiver: synchronizes clk/data, deserializes 11-bit frames, buffers bytes
// in a FIFO and decodes E0/F0 prefixes into key events with valid/ready.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int unsigned PS2DIV    = 1000,
   parameter int unsigned TIMEOUT   = 8 * PS2DIV,
   parameter int unsigned FIFO_BITS = 3,
   parameter int unsigned DECODE    = 1
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [7:0] evt_code,
   output logic       evt_pressed,
   output logic       evt_extended,
   output logic       rx_err,
   output logic       overflow
);

   localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
   localparam logic [2:0]  LastBit = 3'(PS2_DATA_BITS - 1);

   // ---------------- input conditioning ----------------
   logic clk_meta_q, clk_sync_q, clk_prev_q;
   logic dat_meta_q, dat_sync_q;
   logic fall;

   // Two-flop synchronizers plus one history flop for edge detection; idle high.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
      end else begin
         clk_meta_q <= ps2_clk;
         clk_sync_q <= clk_meta_q;
         clk_prev_q <= clk_sync_q;
         dat_meta_q <= ps2_data;
         dat_sync_q <= dat_meta_q;
      end
   end

   assign fall = clk_prev_q && !clk_sync_q;

   // ---------------- receive FSM ----------------
   ps2_rx_state_e  state_q, state_d;
   logic [7:0]     shreg_q;
   logic [2:0]     bit_cnt_q;
   logic           par_q;
   logic [TmoW-1:0] tmo_cnt_q;
   logic           tmo_hit;
   logic           start, shift, par_ld, frame_ok, frame_bad;
   logic           push_q, err_q;

   assign tmo_hit = (state_q != StIdle) && !fall && (tmo_cnt_q == TmoW'(TIMEOUT));

   // State register.
   always_ff @(posedge clk_sys) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state: advance on each falling edge, abort to idle on timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (fall && !dat_sync_q) state_d = StData;
         StData: begin
            if (tmo_hit)                           state_d = StIdle;
            else if (fall && bit_cnt_q == LastBit) state_d = StParity;
         end
         StParity: begin
            if (tmo_hit)   state_d = StIdle;
            else if (fall) state_d = StStop;
         end
         StStop: begin
            if (tmo_hit)   state_d = StIdle;
            else if (fall) state_d = StIdle;
         end
         default:  state_d = StIdle;
      endcase
   end

   // Outputs of the FSM: datapath strobes and frame verdict.
   always_comb begin
      start     = 1'b0;
      shift     = 1'b0;
      par_ld    = 1'b0;
      frame_ok  = 1'b0;
      frame_bad = 1'b0;
      unique case (state_q)
         StIdle:   start  = fall && !dat_sync_q;
         StData:   shift  = fall;
         StParity: par_ld = fall;
         StStop: begin
            frame_ok  = fall && dat_sync_q && ps2_parity_ok(shreg_q, par_q);
            frame_bad = fall && !(dat_sync_q && ps2_parity_ok(shreg_q, par_q));
         end
         default: ;
      endcase
   end

   // Datapath: shift register, bit counter, parity latch, timeout and pulses.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         par_q     <= 1'b0;
         tmo_cnt_q <= '0;
         push_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (start)      bit_cnt_q <= '0;
         else if (shift) bit_cnt_q <= bit_cnt_q + 3'd1;
         if (shift)  shreg_q <= {dat_sync_q, shreg_q[7:1]};
         if (par_ld) par_q   <= dat_sync_q;
         if (state_q == StIdle || fall) tmo_cnt_q <= '0;
         else if (!tmo_hit)             tmo_cnt_q <= tmo_cnt_q + 1'b1;
         push_q <= frame_ok;
         err_q  <= frame_bad || tmo_hit;
      end
   end

   // ---------------- byte FIFO ----------------
   logic [7:0] fifo_dout;
   logic       fifo_full, fifo_empty, pop;
   logic       ovf_q;

   ps2_byte_fifo #(
      .FIFO_BITS (FIFO_BITS)
   ) u_fifo (
      .clk_sys (clk_sys),
      .reset   (reset),
      .push    (push_q),
      .din     (shreg_q),
      .pop     (pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Sticky overflow: a completed byte found the FIFO full.
   always_ff @(posedge clk_sys) begin
      if (reset)                      ovf_q <= 1'b0;
      else if (push_q && fifo_full)   ovf_q <= 1'b1;
   end

   // ---------------- prefix decoder ----------------
   ps2_evt_t evt_q;
   logic     evt_valid_q;
   logic     ext_q, brk_q;
   logic     is_ext, is_brk;

   assign pop    = !fifo_empty && (!evt_valid_q || evt_ready);
   assign is_ext = (DECODE != 0) && (fifo_dout == PS2_EXT);
   assign is_brk = (DECODE != 0) && (fifo_dout == PS2_BRK);

   // Output register: prefixes only set flags, any other byte becomes an event.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         evt_q       <= '0;
         evt_valid_q <= 1'b0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
      end else begin
         if (evt_valid_q && evt_ready) evt_valid_q <= 1'b0;
         if (pop) begin
            if (is_ext) begin
               ext_q <= 1'b1;
            end else if (is_brk) begin
               brk_q <= 1'b1;
            end else begin
               evt_q.code     <= fifo_dout;
               evt_q.extended <= ext_q;
               evt_q.pressed  <= !brk_q;
               evt_valid_q    <= 1'b1;
               ext_q          <= 1'b0;
               brk_q          <= 1'b0;
            end
         end
      end
   end

   assign evt_valid    = evt_valid_q;
   assign evt_code     = evt_q.code;
   assign evt_pressed  = evt_q.pressed;
   assign evt_extended = evt_q.extended;
   assign rx_err       = err_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx with a byte-level reference model.
module tb_ps2_rx;

   localparam int unsigned PS2DIV  = 10;
   localparam int unsigned TIMEOUT = 8 * PS2DIV;

   logic       clk_sys = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       evt_ready = 1'b0;
   logic       evt_valid;
   logic [7:0] evt_code;
   logic       evt_pressed;
   logic       evt_extended;
   logic       rx_err;
   logic       overflow;

   int vectors = 0;
   int miscompares = 0;
   int err_cnt = 0;
   int ready_mode = 0;  // 0 = low, 1 = high, 2 = random
   logic [9:0] got_q[$];
   logic [9:0] exp_q[$];
   logic ext_m = 1'b0;
   logic brk_m = 1'b0;

   ps2_rx #(
      .PS2DIV    (PS2DIV),
      .TIMEOUT   (TIMEOUT),
      .FIFO_BITS (3),
      .DECODE    (1)
   ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_code     (evt_code),
      .evt_pressed  (evt_pressed),
      .evt_extended (evt_extended),
      .rx_err       (rx_err),
      .overflow     (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) begin
      #1;
      case (ready_mode)
         0:       evt_ready = 1'b0;
         1:       evt_ready = 1'b1;
         default: evt_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: collect accepted events, count error pulses, check hold while stalled.
   logic       stall_p = 1'b0;
   logic [10:0] held = '0;
   always @(negedge clk_sys) begin
      if (rx_err) err_cnt++;
      if (stall_p && !reset) begin
         vectors++;
         if ({evt_valid, evt_pressed, evt_extended, evt_code} !== held) begin
            miscompares++;
            $display("FAIL hold_stable: got %h need %h",
                     {evt_valid, evt_pressed, evt_extended, evt_code}, held);
         end
      end
      if (evt_valid && evt_ready && !reset) got_q.push_back({evt_pressed, evt_extended, evt_code});
      stall_p = evt_valid && !evt_ready && !reset;
      held    = {evt_valid, evt_pressed, evt_extended, evt_code};
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   // Drive the first nbits of a frame; data changes while the clock is high.
   task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         cyc(PS2DIV);
         ps2_clk = 1'b0;
         cyc(PS2DIV);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      cyc(2 * PS2DIV);
   endtask

   // Reference model: byte stream -> expected events {pressed, extended, code}.
   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hE0)      ext_m = 1'b1;
      else if (b == 8'hF0) brk_m = 1'b1;
      else begin
         exp_q.push_back({~brk_m, ext_m, b});
         ext_m = 1'b0;
         brk_m = 1'b0;
      end
   endtask

   task automatic send_good(input logic [7:0] b);
      send_bits(b, 1'b0, 11);
      model_byte(b);
   endtask

   task automatic wait_events(input int n);
      for (int i = 0; i < 20000 && got_q.size() < n; i++) cyc(1);
      cyc(20);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      cyc(5);
      vectors++;
      if ({evt_valid, evt_code, evt_pressed, evt_extended, rx_err, overflow} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b need 0",
                  {evt_valid, evt_code, evt_pressed, evt_extended, rx_err, overflow});
      end
      reset = 1'b0;
      ext_m = 1'b0;
      brk_m = 1'b0;
      cyc(5);
   endtask

   task automatic test_make;
      int e0;
      got_q.delete(); exp_q.delete();
      ready_mode = 1;
      e0 = err_cnt;
      send_good(8'h1C);
      wait_events(1);
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== 10'h21C) begin
         miscompares++;
         $display("FAIL make_1c: got n=%0d ev=%h need n=1 ev=21c", got_q.size(),
                  got_q.size() > 0 ? got_q[0] : 10'h0);
      end
      vectors++;
      if (err_cnt != e0) begin
         miscompares++;
         $display("FAIL make_no_err: got %0d errs need 0", err_cnt - e0);
      end
   endtask

   task automatic test_prefix;
      got_q.delete(); exp_q.delete();
      ready_mode = 1;
      send_good(8'hF0); send_good(8'h1C);
      send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
      wait_events(2);
      vectors++;
      if (got_q.size() != 2) begin
         miscompares++;
         $display("FAIL prefix_count: got %0d need 2", got_q.size());
      end
      for (int i = 0; i < 2 && i < got_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== (i == 0 ? 10'h01C : 10'h175)) begin
            miscompares++;
            $display("FAIL prefix_event%0d: got %h need %h", i, got_q[i],
                     i == 0 ? 10'h01C : 10'h175);
         end
      end
   endtask

   task automatic test_parity;
      int e0;
      got_q.delete(); exp_q.delete();
      ready_mode = 1;
      e0 = err_cnt;
      send_bits(8'h1C, 1'b1, 11);
      cyc(20);
      vectors++;
      if (err_cnt - e0 != 1 || got_q.size() != 0) begin
         miscompares++;
         $display("FAIL parity_err: got errs=%0d events=%0d need errs=1 events=0",
                  err_cnt - e0, got_q.size());
      end
      send_good(8'h29);
      wait_events(1);
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== 10'h229) begin
         miscompares++;
         $display("FAIL parity_recover: got n=%0d need code 29", got_q.size());
      end
   endtask

   task automatic test_timeout;
      int e0;
      got_q.delete(); exp_q.delete();
      ready_mode = 1;
      e0 = err_cnt;
      send_bits(8'h5A, 1'b0, 5);
      cyc(TIMEOUT + 10);
      vectors++;
      if (err_cnt - e0 != 1 || got_q.size() != 0) begin
         miscompares++;
         $display("FAIL timeout_err: got errs=%0d events=%0d need errs=1 events=0",
                  err_cnt - e0, got_q.size());
      end
      send_good(8'h29);
      wait_events(1);
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== 10'h229) begin
         miscompares++;
         $display("FAIL timeout_recover: got n=%0d need code 29", got_q.size());
      end
   endtask

   task automatic test_overflow;
      got_q.delete(); exp_q.delete();
      ready_mode = 0;
      for (int i = 1; i <= 10; i++) begin
         send_bits(8'(i), 1'b0, 11);
         if (i <= 9) model_byte(8'(i));  // 1 output register + 8 FIFO entries
      end
      cyc(20);
      vectors++;
      if (overflow !== 1'b1 || evt_valid !== 1'b1 || evt_code !== 8'h01) begin
         miscompares++;
         $display("FAIL overflow_state: got ovf=%b valid=%b code=%h need 1 1 01",
                  overflow, evt_valid, evt_code);
      end
      ready_mode = 1;
      wait_events(exp_q.size());
      vectors++;
      if (got_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL overflow_count: got %0d need %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL overflow_order%0d: got %h need %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      got_q.delete(); exp_q.delete();
      ready_mode = 1;
      send_bits(8'h33, 1'b0, 5);
      reset = 1'b1;
      cyc(3);
      vectors++;
      if ({evt_valid, evt_code, evt_pressed, evt_extended, rx_err, overflow} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: got %b need 0",
                  {evt_valid, evt_code, evt_pressed, evt_extended, rx_err, overflow});
      end
      reset = 1'b0;
      ext_m = 1'b0;
      brk_m = 1'b0;
      cyc(TIMEOUT + 20);
      vectors++;
      if (got_q.size() != 0) begin
         miscompares++;
         $display("FAIL reset_mid_no_event: got %0d need 0", got_q.size());
      end
      send_good(8'h1C);
      wait_events(1);
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== 10'h21C) begin
         miscompares++;
         $display("FAIL reset_mid_recover: got n=%0d need code 1c", got_q.size());
      end
   endtask

   task automatic test_random;
      int e0, bad_n;
      logic [7:0] b;
      bit bad;
      got_q.delete(); exp_q.delete();
      ready_mode = 2;
      e0 = err_cnt;
      bad_n = 0;
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 7))
            0:       b = 8'hE0;
            1:       b = 8'hF0;
            default: b = 8'($urandom);
         endcase
         bad = ($urandom_range(0, 9) == 0);
         send_bits(b, bad, 11);
         if (bad) bad_n++;
         else     model_byte(b);
      end
      wait_events(exp_q.size());
      vectors++;
      if (got_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL random_count: got %0d need %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL random_event%0d: got %h need %h", i, got_q[i], exp_q[i]);
         end
      end
      vectors++;
      if (err_cnt - e0 != bad_n || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL random_err: got errs=%0d ovf=%b need errs=%0d ovf=0",
                  err_cnt - e0, overflow, bad_n);
      end
   endtask

   initial begin
      test_reset();
      test_make();
      test_prefix();
      test_parity();
      test_timeout();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

Receiver end of the PS/2 serial link driven by `hps_io`. It deserializes PS/2 keyboard or mouse frames from the `ps2_kbd_clk`/`ps2_kbd_data` pair (or the mouse pair) into bytes and buffers them in a small FIFO. A prefix decoder turns the buffered bytes into key events with a valid/ready handshake. It sits inside a core between `hps_io` and the core's keyboard matrix or mouse logic, entirely in the `clk_sys` domain.

## Interface
- `PS2DIV`, 1000: `hps_io` PS/2 divider; one PS/2 bit period = 2*PS2DIV `clk_sys` cycles.
- `TIMEOUT`, 8*PS2DIV: `clk_sys` cycles without a falling `ps2_clk` edge mid-frame before the frame is aborted.
- `FIFO_BITS`, 3: log2 of raw-byte FIFO depth (8 entries).
- `DECODE`, 1: 1 = E0/F0 prefix decoding; 0 = every byte is emitted raw (`evt_pressed`=1, `evt_extended`=0).

Ports:
- `clk_sys` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `ps2_clk` in 1: PS/2 clock from `hps_io`; idle high.
- `ps2_data` in 1: PS/2 data from `hps_io`.
- `evt_valid` out 1: event available.
- `evt_ready` in 1: consumer accepts the event when high together with `evt_valid`.
- `evt_code` out 8: scan code or raw byte.
- `evt_pressed` out 1: 1 = make, 0 = break (F0 seen).
- `evt_extended` out 1: E0 prefix seen.
- `rx_err` out 1: one-cycle pulse on a parity, stop-bit or timeout error.
- `overflow` out 1: sticky; set when a byte is dropped because the FIFO is full.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` pass through 2-flop synchronizers.
  - A falling edge is detected on the synchronized clock: the previous value was 1 and the current value is 0.
  - Data is sampled on that edge. The transmitter changes data on the rising edge.
- **Frame format**: 11 bits.
  - Start bit = 0.
  - 8 data bits, LSB first.
  - Odd parity: data ones plus the parity bit is odd.
  - Stop bit = 1.
- **Receive FSM**
  - IDLE: on a falling edge, if data = 0, go to DATA with bit_cnt = 0. If data = 1, treat it as a glitch and stay in IDLE with no error.
  - DATA: shift the sampled bit into shreg[7] and shift right. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP: check that the stop bit = 1 and that parity is odd.
    - Pass: push shreg to the FIFO and return to IDLE.
    - Fail: drop the byte, pulse `rx_err`, and return to IDLE.
  - Timeout counter: resets on every falling edge and runs in every state except IDLE. When it reaches TIMEOUT, abort to IDLE and pulse `rx_err`. No push occurs.
- **FIFO**
  - 2^FIFO_BITS entries with wrapping pointers.
  - Full is detected by an extra pointer MSB.
  - A push while full drops the byte and sets `overflow`.
  - A push and a pop in the same cycle are both allowed when the FIFO is non-empty.
- **Decoder**
  - Owns a one-entry output register (`evt_*`).
  - Pops a byte when the FIFO is not empty and either `evt_valid` = 0 or `evt_valid` and `evt_ready` are both high.
  - Byte E0: set `ext_f`; no event.
  - Byte F0: set `brk_f`; no event.
  - Any other byte, including E1 and AA: load `evt_code` = byte, `evt_extended` = `ext_f`, `evt_pressed` = ~`brk_f`. Set `evt_valid` and clear both flags.
  - When DECODE = 0, prefix handling is bypassed.
- **Accept**: `evt_valid`, `evt_ready` both high with no new pop deasserts `evt_valid` next cycle.

## Timing
- **Reset values**:
  - `evt_valid`, `evt_code`, `evt_pressed`, `evt_extended`, `rx_err`, `overflow`: all 0.
  - Prefix flags: cleared.
  - FIFO: emptied.
  - FSM: IDLE.
- Reset mid-frame discards the partial byte. The next frame is received normally.
- Edge-detect latency: the falling edge is detected 3 `clk_sys` cycles after `ps2_clk` falls.
- Push occurs the cycle after the stop-bit edge is detected.
- `evt_valid` rises 2 cycles after the push if the output register is free.
- `evt_valid` holds and outputs are stable until accepted. Back-to-back events can be accepted every cycle.
- Capacity with `evt_ready` = 0: 1 output register + 2^FIFO_BITS FIFO entries.
- `rx_err` and `overflow` set can coincide. `overflow` clears only on `reset`.

## Structure
- Package `ps2_pkg` holds:
  - Constants `PS2_EXT` = 8'hE0, `PS2_BRK` = 8'hF0, `PS2_FRAME_BITS` = 11.
  - The receive FSM state enum.
  - The event struct {pressed, extended, code}.
- Sub-module `ps2_byte_fifo`: a synchronous FIFO with parameter FIFO_BITS and push/pop/full/empty. It is also reused for a mouse instance.
- Two instances of `ps2_rx` serve keyboard and mouse. The mouse instance uses DECODE = 0.

## Test plan
- Frame 8'h1C with parity 0 and stop 1, `evt_ready` = 1 -> one event: code 1C, pressed 1, extended 0; `rx_err` stays 0.
- Bytes F0, 1C -> exactly one event: code 1C, pressed 0, extended 0. Bytes E0, F0, 75 -> one event: code 75, pressed 0, extended 1.
- Frame 8'h1C with parity 1 -> `rx_err` pulses once; no event; the following good 8'h29 frame decodes as code 29.
- `ps2_clk` held high after 4 data bits for TIMEOUT+10 cycles -> `rx_err` pulses once; FSM returns to IDLE; the next 8'h29 frame decodes correctly.
- `evt_ready` = 0 with bytes 01..0A sent -> 01..09 are retained and `overflow` = 1. Releasing `evt_ready` then yields 01..09 in order with no 0A.
- `reset` asserted after 5 bits of a frame -> all outputs return to 0 and no event appears. A full 8'h1C frame after reset yields code 1C.
